// File: rtl/moving_average_pkg.sv
// Shared types and helpers for the runtime-selectable boxcar averager.
package moving_average_pkg;

    localparam int DATA_W_DEFAULT    = 10;
    localparam int MAX_POWER_DEFAULT = 4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Window exponents above the ring capacity fall back to the largest window.
    function automatic int unsigned clamp_power(input int unsigned sel, input int unsigned max_power);
        return (sel > max_power) ? max_power : sel;
    endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// Register-array ring: one write port with a wrapping write pointer, one
// combinational read port addressed as a distance back from the write pointer.
module sample_ring_buffer #(
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_back,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [DEPTH-1:0]  wr_sel;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_en && (wr_ptr_reg == ADDR_W'(gi));
    end

    // Storage is deliberately never cleared; consumers mask stale entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
        end else if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
        end
    end

    assign rd_data = mem[wr_ptr_reg - rd_back];

endmodule

// File: rtl/moving_average_var_window.sv
// Boxcar averager with runtime window 2^p over a shared ring and running sum.
// Define MOVING_AVERAGE_ROUND_EN for round-half-up averaging instead of truncation.
module moving_average_var_window
    import moving_average_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MAX_POWER = MAX_POWER_DEFAULT,
    parameter int SEL_W     = $clog2(MAX_POWER + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              strobe_in,
    input  logic [SEL_W-1:0]  win_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              strobe_out,
    output logic              filled,
    output logic              busy
);

    localparam int SUM_W = DATA_W + MAX_POWER;
    localparam int CNT_W = MAX_POWER + 1;

    state_t            state_reg, state_next;
    logic              init_reg;
    logic [SEL_W-1:0]  active_power_reg, active_power_next;
    logic [SUM_W-1:0]  sum_reg, sum_next;
    logic [CNT_W-1:0]  fill_cnt_reg, fill_cnt_next;
    logic [DATA_W-1:0] data_out_reg, data_out_next;
    logic              strobe_out_reg, strobe_out_next;
    logic              filled_reg, filled_next;

    logic [SEL_W-1:0]  sel_clamped;
    logic [SEL_W-1:0]  power;
    logic [CNT_W-1:0]  n_win;
    logic              win_change;
    logic              accept;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] x_old;
    logic [SUM_W-1:0]  sum_acc;
    logic [DATA_W-1:0] avg;

    assign sel_clamped = SEL_W'(clamp_power(32'(win_sel), MAX_POWER));

    // The first clock after reset adopts the requested window without a flush.
    assign power      = init_reg ? sel_clamped : active_power_reg;
    assign win_change = !init_reg && (sel_clamped != active_power_reg);
    assign n_win      = CNT_W'(1) << power;
    assign accept     = (state_reg == RUN) && !win_change && strobe_in;

    // Sample leaving the window; zero until the window has been primed.
    assign x_old   = (fill_cnt_reg == n_win) ? rd_data : '0;
    assign sum_acc = sum_reg + SUM_W'(data_in) - SUM_W'(x_old);

`ifdef MOVING_AVERAGE_ROUND_EN
    logic [SUM_W:0] rounded;
    logic [SUM_W:0] rounded_shift;

    always_comb begin
        rounded = {1'b0, sum_acc};
        if (power != '0) begin
            rounded = {1'b0, sum_acc} + ((SUM_W + 1)'(1) << (power - SEL_W'(1)));
        end
    end

    assign rounded_shift = rounded >> power;
    assign avg           = DATA_W'(rounded_shift);
`else
    logic [SUM_W-1:0] trunc_shift;

    assign trunc_shift = sum_acc >> power;
    assign avg         = DATA_W'(trunc_shift);
`endif

    sample_ring_buffer #(
        .WIDTH  (DATA_W),
        .ADDR_W (MAX_POWER)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data (data_in),
        .rd_back (n_win[MAX_POWER-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        state_next        = state_reg;
        active_power_next = power;
        sum_next          = sum_reg;
        fill_cnt_next     = fill_cnt_reg;
        data_out_next     = data_out_reg;
        strobe_out_next   = 1'b0;

        case (state_reg)
            RUN: begin
                if (win_change) begin
                    state_next = FLUSH;
                end else if (strobe_in) begin
                    sum_next        = sum_acc;
                    fill_cnt_next   = (fill_cnt_reg == n_win) ? n_win : fill_cnt_reg + CNT_W'(1);
                    data_out_next   = avg;
                    strobe_out_next = 1'b1;
                end
            end
            FLUSH: begin
                sum_next          = '0;
                fill_cnt_next     = '0;
                active_power_next = sel_clamped;
                state_next        = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase

        filled_next = (fill_cnt_next == n_win);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= RUN;
            init_reg         <= 1'b1;
            active_power_reg <= '0;
            sum_reg          <= '0;
            fill_cnt_reg     <= '0;
            data_out_reg     <= '0;
            strobe_out_reg   <= 1'b0;
            filled_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            init_reg         <= 1'b0;
            active_power_reg <= active_power_next;
            sum_reg          <= sum_next;
            fill_cnt_reg     <= fill_cnt_next;
            data_out_reg     <= data_out_next;
            strobe_out_reg   <= strobe_out_next;
            filled_reg       <= filled_next;
        end
    end

    assign data_out   = data_out_reg;
    assign strobe_out = strobe_out_reg;
    assign filled     = filled_reg;
    assign busy       = (state_reg == FLUSH);

endmodule

// File: tb/tb_moving_average_var_window.sv
// Directed plus randomized bench for moving_average_var_window against a
// queue-based window-average model.
module tb_moving_average_var_window;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] data_in;
    logic       strobe_in;
    logic [2:0] win_sel;
    logic [9:0] data_out;
    logic       strobe_out;
    logic       filled;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int hist[$];
    int p_m;
    int strobe_cnt;

    moving_average_var_window dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .strobe_in  (strobe_in),
        .win_sel    (win_sel),
        .data_out   (data_out),
        .strobe_out (strobe_out),
        .filled     (filled),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clampw(input int w);
        return (w > 4) ? 4 : w;
    endfunction

    // Average of the last 2^p accepted samples, missing ones counted as zero.
    function automatic int exp_avg();
        int n = 1 << p_m;
        int s = 0;
        for (int i = 0; i < n && i < hist.size(); i++) s += hist[hist.size() - 1 - i];
`ifdef MOVING_AVERAGE_ROUND_EN
        if (p_m > 0) s += 1 << (p_m - 1);
`endif
        return s >> p_m;
    endfunction

    function automatic int exp_filled();
        return (hist.size() >= (1 << p_m)) ? 1 : 0;
    endfunction

    task automatic send(input int x);
        data_in   = 10'(x);
        strobe_in = 1'b1;
        @(posedge clk);
        #1;
        hist.push_back(x);
        if (hist.size() > 16) void'(hist.pop_front());
        check("avg", 32'(data_out), exp_avg());
        check("strobe_out", 32'(strobe_out), 1);
        check("filled", 32'(filled), exp_filled());
        check("busy_run", 32'(busy), 0);
        if (strobe_out) strobe_cnt++;
    endtask

    task automatic idle();
        strobe_in = 1'b0;
        @(posedge clk);
        #1;
        check("idle_strobe", 32'(strobe_out), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_filled", 32'(filled), exp_filled());
    endtask

    task automatic change_win(input int w, input bit with_strobe);
        win_sel = 3'(w);
        if (clampw(w) == p_m) begin
            idle();
        end else begin
            strobe_in = with_strobe;
            data_in   = 10'($urandom_range(0, 1023));
            @(posedge clk);
            #1;
            check("chg_strobe", 32'(strobe_out), 0);
            check("chg_busy", 32'(busy), 1);
            @(posedge clk);
            #1;
            strobe_in = 1'b0;
            check("flush_strobe", 32'(strobe_out), 0);
            check("flush_busy", 32'(busy), 0);
            check("flush_filled", 32'(filled), 0);
            hist.delete();
            p_m = clampw(w);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        win_sel   = 3'd1;
        strobe_in = 1'b0;
        data_in   = '0;
        p_m       = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_out", 32'(data_out), 0);
        check("rst_strobe", 32'(strobe_out), 0);
        check("rst_filled", 32'(filled), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        idle();

        // p=1 ramp-up
        send(10); check("t1_out0", 32'(data_out), 5);  check("t1_fill0", 32'(filled), 0);
        send(20); check("t1_out1", 32'(data_out), 15); check("t1_fill1", 32'(filled), 1);
        send(30); check("t1_out2", 32'(data_out), 25);
        idle();

        // p=2 constant input
        change_win(2, 1'b0);
        for (int i = 0; i < 5; i++) send(100);
        check("t2_final", 32'(data_out), 100);
        idle();

        // window change coinciding with a strobe
        change_win(3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send(80);
            check("t3_ramp", 32'(data_out), 32'(10 * (i + 1)));
        end
        idle();

        // widest window, back-to-back full-scale
        change_win(4, 1'b0);
        strobe_cnt = 0;
        for (int i = 0; i < 20; i++) send(1023);
        idle();
        check("t4_count", 32'(strobe_cnt), 20);
        check("t4_final", 32'(data_out), 1023);

        // clamp of out-of-range selection, then rounding behaviour
        change_win(7, 1'b0);
        change_win(1, 1'b0);
        send(0);
        send(3);
`ifdef MOVING_AVERAGE_ROUND_EN
        check("t5_round", 32'(data_out), 2);
`else
        check("t5_trunc", 32'(data_out), 1);
`endif
        idle();
        change_win(7, 1'b0);
        check("t5_clamp_filled", 32'(filled), 0);
        for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 1023)));
        idle();

        // randomized mix of samples, gaps and window changes
        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) change_win(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            else if (r <= 2) idle();
            else send(int'($urandom_range(0, 1023)));
        end

        // asynchronous reset mid-stream
        change_win(1, 1'b0);
        send(500);
        send(300);
        strobe_in = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_data_out", 32'(data_out), 0);
        check("t6_strobe", 32'(strobe_out), 0);
        check("t6_filled", 32'(filled), 0);
        check("t6_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hist.delete();
        p_m = 1;
        idle();
        idle();
        send(4); check("t6_out0", 32'(data_out), 2);
        send(4); check("t6_out1", 32'(data_out), 4);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
